// File: rtl/adc_seq_ctrl_if.sv
// Control/data bundle for adc_seq_ctrl: run/mute requests, PCM in/out, strobes and status.
// The clip-detect signals exist only when ADC_SEQ_CLIP_DET_EN is defined.
interface adc_seq_ctrl_if;
  logic               enable;
  logic               mute_req;
  logic signed [31:0] pcm_left_in;
  logic signed [31:0] pcm_right_in;
  logic               dsd_stb;
  logic               frame176_stb;
  logic               frame88_stb;
  logic               ch_sel;
  logic [15:0]        gain;
  logic signed [31:0] pcm_left_out;
  logic signed [31:0] pcm_right_out;
  logic               out_valid;
  logic [2:0]         state;
`ifdef ADC_SEQ_CLIP_DET_EN
  logic               clip_clr;
  logic               clip_flag;

  modport master (
    output enable, mute_req, pcm_left_in, pcm_right_in, clip_clr,
    input  dsd_stb, frame176_stb, frame88_stb, ch_sel, gain,
           pcm_left_out, pcm_right_out, out_valid, state, clip_flag
  );
  modport slave (
    input  enable, mute_req, pcm_left_in, pcm_right_in, clip_clr,
    output dsd_stb, frame176_stb, frame88_stb, ch_sel, gain,
           pcm_left_out, pcm_right_out, out_valid, state, clip_flag
  );
`else
  modport master (
    output enable, mute_req, pcm_left_in, pcm_right_in,
    input  dsd_stb, frame176_stb, frame88_stb, ch_sel, gain,
           pcm_left_out, pcm_right_out, out_valid, state
  );
  modport slave (
    input  enable, mute_req, pcm_left_in, pcm_right_in,
    output dsd_stb, frame176_stb, frame88_stb, ch_sel, gain,
           pcm_left_out, pcm_right_out, out_valid, state
  );
`endif
endinterface

// File: rtl/adc_seq_ctrl.sv
// Timing sequencer, start-up/mute FSM and gain gate for the DSD128 -> 88.2 kHz PCM ADC chain.
// Optional sticky clip detector is compiled in with ADC_SEQ_CLIP_DET_EN.
module adc_seq_ctrl #(
  parameter int SETTLE_FRAMES = 176400,
  parameter int RAMP_STEP     = 64
) (
  input  logic          mclk,
  input  logic          reset,
  adc_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    RAMP_UP = 3'd2,
    RUN     = 3'd3,
    RAMP_DN = 3'd4,
    MUTED   = 3'd5
  } state_e;

  localparam int               CNT_W       = $clog2(SETTLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [15:0]      UNITY       = 16'h8000;
  localparam logic [15:0]      STEP        = 16'(RAMP_STEP);

  logic [8:0]         ph_q, ph_d;
  logic               dsd_stb_q, dsd_stb_d;
  logic               f176_q, f176_d;
  logic               f88_q, f88_d;
  logic               ch_sel_q, ch_sel_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        gain_q, gain_d;
  logic signed [31:0] pcm_l_q, pcm_l_d;
  logic signed [31:0] pcm_r_q, pcm_r_d;
  logic               valid_q, valid_d;

  logic [16:0]        up_sum;
  logic [15:0]        gain_up, gain_dn;
  logic signed [47:0] pcm_l_ext, pcm_r_ext, gain_ext, prod_l, prod_r;

  // Strobes decode the current phase and appear one cycle later; a dropped enable kills them.
  // NOTE: every always_comb assigns each output a default first, so no path can infer a latch.
  always_comb begin
    ph_d      = bus.enable ? ph_q + 9'd1 : '0;
    dsd_stb_d = bus.enable && (ph_q[2:0] == 3'd7);
    f176_d    = bus.enable && (ph_q[7:0] == 8'hFF);
    f88_d     = bus.enable && (ph_q == 9'h1FF);
    ch_sel_d  = bus.enable && ph_q[7];
  end

  always_comb begin
    up_sum  = {1'b0, gain_q} + {1'b0, STEP};
    gain_up = (up_sum >= 17'(UNITY)) ? UNITY : up_sum[15:0];
    gain_dn = (gain_q > STEP) ? gain_q - STEP : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      gain_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          gain_d  = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (f176_q) begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_d   = '0;
              state_d = bus.mute_req ? MUTED : RAMP_UP;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        // A mute request pre-empts a pending gain step so the ramp reverses from where it is.
        RAMP_UP: begin
          if (bus.mute_req) begin
            state_d = RAMP_DN;
          end else if (f88_q) begin
            gain_d = gain_up;
            if (gain_up == UNITY) state_d = RUN;
          end
        end
        RUN: begin
          gain_d = UNITY;
          if (bus.mute_req) state_d = RAMP_DN;
        end
        RAMP_DN: begin
          if (!bus.mute_req) begin
            state_d = RAMP_UP;
          end else if (f88_q) begin
            gain_d = gain_dn;
            if (gain_dn == '0) state_d = MUTED;
          end
        end
        MUTED: begin
          gain_d = '0;
          if (!bus.mute_req) state_d = RAMP_UP;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          gain_d  = '0;
        end
      endcase
    end
  end

  // Samples are scaled by the gain held before this frame's step; >>> floors toward -inf.
  always_comb begin
    pcm_l_ext = {{16{bus.pcm_left_in[31]}}, bus.pcm_left_in};
    pcm_r_ext = {{16{bus.pcm_right_in[31]}}, bus.pcm_right_in};
    gain_ext  = {32'd0, gain_q};
    prod_l    = pcm_l_ext * gain_ext;
    prod_r    = pcm_r_ext * gain_ext;
    pcm_l_d   = pcm_l_q;
    pcm_r_d   = pcm_r_q;
    valid_d   = 1'b0;
    if (!bus.enable) begin
      pcm_l_d = '0;
      pcm_r_d = '0;
    end else if (f88_q) begin
      pcm_l_d = 32'(prod_l >>> 15);
      pcm_r_d = 32'(prod_r >>> 15);
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      ph_q      <= '0;
      dsd_stb_q <= 1'b0;
      f176_q    <= 1'b0;
      f88_q     <= 1'b0;
      ch_sel_q  <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      gain_q    <= '0;
      pcm_l_q   <= '0;
      pcm_r_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      dsd_stb_q <= dsd_stb_d;
      f176_q    <= f176_d;
      f88_q     <= f88_d;
      ch_sel_q  <= ch_sel_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gain_q    <= gain_d;
      pcm_l_q   <= pcm_l_d;
      pcm_r_q   <= pcm_r_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.dsd_stb       = dsd_stb_q;
  assign bus.frame176_stb  = f176_q;
  assign bus.frame88_stb   = f88_q;
  assign bus.ch_sel        = ch_sel_q;
  assign bus.gain          = gain_q;
  assign bus.pcm_left_out  = pcm_l_q;
  assign bus.pcm_right_out = pcm_r_q;
  assign bus.out_valid     = valid_q;
  assign bus.state         = state_q;

`ifdef ADC_SEQ_CLIP_DET_EN
  localparam logic signed [31:0] CLIP_POS = 32'sh7F00_0000;
  localparam logic signed [31:0] CLIP_NEG = 32'sh8100_0000;

  logic [1:0] clip_run_q, clip_run_d;
  logic       clip_flag_q, clip_flag_d;
  logic       clip_hot, clip_set;

  // A run of three hot samples is remembered; the fourth consecutive one sets the flag.
  always_comb begin
    clip_hot = (bus.pcm_left_in  >= CLIP_POS) || (bus.pcm_left_in  <= CLIP_NEG) ||
               (bus.pcm_right_in >= CLIP_POS) || (bus.pcm_right_in <= CLIP_NEG);
    clip_run_d = clip_run_q;
    clip_set   = 1'b0;
    if (!bus.enable) begin
      clip_run_d = '0;
    end else if (f88_q) begin
      if (!clip_hot)               clip_run_d = '0;
      else if (clip_run_q == 2'd3) clip_set   = 1'b1;
      else                         clip_run_d = clip_run_q + 2'd1;
    end
    clip_flag_d = clip_set ? 1'b1 : (bus.clip_clr ? 1'b0 : clip_flag_q);
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      clip_run_q  <= '0;
      clip_flag_q <= 1'b0;
    end else begin
      clip_run_q  <= clip_run_d;
      clip_flag_q <= clip_flag_d;
    end
  end

  assign bus.clip_flag = clip_flag_q;
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Self-checking bench for adc_seq_ctrl: phase timing, start-up/mute vector table,
// enable/reset corner cases and a randomized run against a frame-level gain model.
module tb_adc_seq_ctrl;

  localparam int SETTLE_FRAMES = 4;
  localparam int RAMP_STEP     = 8192;
  localparam int UNITY         = 32768;
  localparam int MIN32         = -2147483647 - 1;
  localparam int MAX32         = 2147483647;
  localparam int S_IDLE = 0, S_SETTLE = 1, S_UP = 2, S_RUN = 3, S_DN = 4, S_MUTED = 5;

  typedef struct {
    bit mute;
    int pl;
    int pr;
    int st;
    int g;
    int lo;
    int ro;
  } vec_t;

  logic mclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[13];

  adc_seq_ctrl_if bus();

  adc_seq_ctrl #(
    .SETTLE_FRAMES(SETTLE_FRAMES),
    .RAMP_STEP    (RAMP_STEP)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (!bus.out_valid && n < 700);
    check({name, " out_valid"}, bus.out_valid, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " dsd_stb"},  bus.dsd_stb, 0);
    check({name, " f176"},     bus.frame176_stb, 0);
    check({name, " f88"},      bus.frame88_stb, 0);
    check({name, " ch_sel"},   bus.ch_sel, 0);
    check({name, " gain"},     bus.gain, 0);
    check({name, " left"},     bus.pcm_left_out, 0);
    check({name, " right"},    bus.pcm_right_out, 0);
    check({name, " valid"},    bus.out_valid, 0);
    check({name, " state"},    bus.state, S_IDLE);
  endtask

  // floor(x * g / 32768) by integer division, corrected toward minus infinity
  function automatic longint scale(input int x, input int g);
    longint p = longint'(x) * longint'(g);
    longint q = p / 32768;
    if (p < 0 && (p % 32768) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int rand_pcm();
    case ($urandom_range(0, 4))
      0:       return MIN32;
      1:       return MAX32;
      2:       return int'($urandom_range(0, 2000)) - 1000;
      default: return int'($urandom);
    endcase
  endfunction

  int   first_dsd, first_176, first_88, n_dsd, n_176, n_88;
  int   last_dsd, last_176, last_88, last_ch_t, ch_changes, bad_int;
  logic last_ch;
  int   n_strobe, seen, cyc;
  int   m_gain, target, exp_st, pl, pr;
  bit   m_mute;

  initial begin
    vecs[0]  = '{0, 1000, 0,     S_SETTLE, 0,     0,    0};
    vecs[1]  = '{0, 1000, 0,     S_UP,     0,     0,    0};
    vecs[2]  = '{0, 1000, 0,     S_UP,     8192,  0,    0};
    vecs[3]  = '{0, 1000, 0,     S_UP,     16384, 250,  0};
    vecs[4]  = '{1, 1000, -1,    S_DN,     8192,  500,  -1};
    vecs[5]  = '{1, 1000, 100,   S_MUTED,  0,     250,  25};
    vecs[6]  = '{1, 1000, 100,   S_MUTED,  0,     0,    0};
    vecs[7]  = '{0, 1000, MIN32, S_UP,     8192,  0,    0};
    vecs[8]  = '{0, 1000, MIN32, S_UP,     16384, 250,  -536870912};
    vecs[9]  = '{0, 1000, MIN32, S_UP,     24576, 500,  -1073741824};
    vecs[10] = '{0, 1000, MIN32, S_RUN,    32768, 750,  -1610612736};
    vecs[11] = '{0, 1000, MIN32, S_RUN,    32768, 1000, MIN32};
    vecs[12] = '{0, 1000, MAX32, S_RUN,    32768, 1000, MAX32};

    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.mute_req     = 1'b0;
    bus.pcm_left_in  = '0;
    bus.pcm_right_in = '0;
`ifdef ADC_SEQ_CLIP_DET_EN
    bus.clip_clr     = 1'b0;
`endif
    repeat (3) @(negedge mclk);
    check_all_zero("reset");
    reset = 1'b0;

    // ---- phase timing over the first 1024 cycles after enable ----
    bus.enable = 1'b1;
    {first_dsd, first_176, first_88, n_dsd, n_176, n_88} = '0;
    {last_dsd, last_176, last_88, last_ch_t, ch_changes, bad_int} = '0;
    last_ch = 1'b0;
    for (int c = 1; c <= 1024; c++) begin
      @(negedge mclk);
      if (bus.dsd_stb) begin
        if (n_dsd == 0) first_dsd = c; else if (c - last_dsd != 8) bad_int++;
        last_dsd = c; n_dsd++;
      end
      if (bus.frame176_stb) begin
        if (n_176 == 0) first_176 = c; else if (c - last_176 != 256) bad_int++;
        last_176 = c; n_176++;
      end
      if (bus.frame88_stb) begin
        if (n_88 == 0) first_88 = c; else if (c - last_88 != 512) bad_int++;
        last_88 = c; n_88++;
      end
      if (bus.ch_sel !== last_ch) begin
        if (ch_changes > 0 && c - last_ch_t != 128) bad_int++;
        ch_changes++; last_ch_t = c; last_ch = bus.ch_sel;
      end
    end
    check("first dsd_stb cycle", first_dsd, 8);
    check("first frame176 cycle", first_176, 256);
    check("first frame88 cycle", first_88, 512);
    check("dsd_stb count", n_dsd, 128);
    check("frame176 count", n_176, 4);
    check("frame88 count", n_88, 2);
    check("ch_sel toggles", ch_changes, 7);
    check("strobe intervals bad", bad_int, 0);
    bus.enable = 1'b0;
    @(negedge mclk);
    check("disable state", bus.state, S_IDLE);
    @(negedge mclk);

    // ---- start-up, mute mid-ramp, release, rounding and full scale ----
    for (int i = 0; i < 13; i++) begin
      bus.mute_req     = vecs[i].mute;
      bus.pcm_left_in  = vecs[i].pl;
      bus.pcm_right_in = vecs[i].pr;
      bus.enable       = 1'b1;
      wait_valid($sformatf("vec%0d", i));
      check($sformatf("vec%0d state", i), bus.state, vecs[i].st);
      check($sformatf("vec%0d gain", i), bus.gain, vecs[i].g);
      check($sformatf("vec%0d left", i), bus.pcm_left_out, vecs[i].lo);
      check($sformatf("vec%0d right", i), bus.pcm_right_out, vecs[i].ro);
    end

    // ---- drop enable in RUN ----
    bus.enable = 1'b0;
    @(negedge mclk);
    check("drop en state", bus.state, S_IDLE);
    check("drop en gain", bus.gain, 0);
    check("drop en left", bus.pcm_left_out, 0);
    check("drop en right", bus.pcm_right_out, 0);
    n_strobe = 0;
    repeat (600) begin
      @(negedge mclk);
      if (bus.dsd_stb || bus.frame176_stb || bus.frame88_stb || bus.out_valid) n_strobe++;
    end
    check("drop en strobes", n_strobe, 0);

    // ---- mute request in the same cycle settling completes ----
    bus.mute_req = 1'b0;
    bus.enable   = 1'b1;
    seen = 0;
    cyc  = 0;
    do begin
      @(negedge mclk);
      cyc++;
      if (bus.frame176_stb) seen++;
    end while (seen < SETTLE_FRAMES && cyc < 1500);
    check("settle strobes seen", seen, SETTLE_FRAMES);
    bus.mute_req = 1'b1;
    @(negedge mclk);
    check("simul mute state", bus.state, S_MUTED);
    check("simul mute gain", bus.gain, 0);
    wait_valid("simul mute frame");
    check("simul mute gain held", bus.gain, 0);
    check("simul mute state held", bus.state, S_MUTED);

    // ---- reset mid RAMP_UP ----
    bus.mute_req = 1'b0;
    wait_valid("pre-reset ramp");
    check("pre-reset state", bus.state, S_UP);
    check("pre-reset gain", bus.gain, RAMP_STEP);
    @(negedge mclk);
    #2 reset = 1'b1;
    #1;
    check_all_zero("reset mid ramp");
    bus.enable = 1'b0;
    @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    check_all_zero("after reset");

    // ---- randomized run against frame-level model ----
    bus.enable   = 1'b1;
    bus.mute_req = 1'b0;
    wait_valid("rand settle a");
    wait_valid("rand settle b");
    check("rand start state", bus.state, S_UP);
    m_gain = 0;
    m_mute = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) m_mute = ~m_mute;
      pl = rand_pcm();
      pr = rand_pcm();
      bus.mute_req     = m_mute;
      bus.pcm_left_in  = pl;
      bus.pcm_right_in = pr;
      @(negedge mclk);
      check("rand valid width", bus.out_valid, 0);
      wait_valid($sformatf("rand%0d", f));
      check($sformatf("rand%0d left", f), bus.pcm_left_out, scale(pl, m_gain));
      check($sformatf("rand%0d right", f), bus.pcm_right_out, scale(pr, m_gain));
      target = m_mute ? 0 : UNITY;
      if (m_gain < target) m_gain = (m_gain + RAMP_STEP > target) ? target : m_gain + RAMP_STEP;
      else                 m_gain = (m_gain - RAMP_STEP < target) ? target : m_gain - RAMP_STEP;
      if (m_mute) exp_st = (m_gain == 0) ? S_MUTED : S_DN;
      else        exp_st = (m_gain == UNITY) ? S_RUN : S_UP;
      check($sformatf("rand%0d gain", f), bus.gain, m_gain);
      check($sformatf("rand%0d state", f), bus.state, exp_st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Timing sequencer and output gate for the DSD128-to-88.2 kHz PCM ADC chain, running at mclk (45.1584 MHz).
- Generates the DSD sample, 176.4 kHz and 88.2 kHz frame strobes that pace the decimator and DC-kill stages.
- Generates a left/right time-slot select for a shared multiplier.
- Runs the start-up/mute state machine: holds output muted while the DC filter settles, then soft-ramps the PCM gain up and down.

Parameters:
- SETTLE_FRAMES, 176400, number of 176.4 kHz frames to hold mute after enable (1 s).
- RAMP_STEP, 64, gain increment/decrement per 88.2 kHz frame; full ramp is 512 frames (~5.8 ms).

Ports:
- mclk  in  1  system clock, 45.1584 MHz.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- mute_req  in  1  level request to ramp output to silence.
- pcm_left_in  in  32  signed PCM from the down-conversion stage.
- pcm_right_in  in  32  signed PCM from the down-conversion stage.
- dsd_stb  out  1  1-cycle pulse every 8 mclk (DSD128 sample point).
- frame176_stb  out  1  1-cycle pulse every 256 mclk.
- frame88_stb  out  1  1-cycle pulse every 512 mclk.
- ch_sel  out  1  shared-resource slot: 0 = left, 1 = right.
- gain  out  16  current unsigned gain; 32768 = unity.
- pcm_left_out  out  32  gated/scaled PCM.
- pcm_right_out  out  32  gated/scaled PCM.
- out_valid  out  1  1-cycle pulse when pcm_*_out update.
- state  out  3  FSM state code.

Behaviour:
- Reset values: all outputs 0, phase counter 0, settle counter 0, state IDLE.
- Phase counter ph[8:0]:
  - Increments every mclk while enable=1 and wraps 511->0.
  - Held at 0 while enable=0.
- Strobe decodes, all registered, asserted in the cycle after ph reaches the decoded value:
  - dsd_stb when ph[2:0]==7.
  - frame176_stb when ph[7:0]==255.
  - frame88_stb when ph==511.
- ch_sel = ph[7], registered; both slots are 128 mclk wide.
- State codes: IDLE=0, SETTLE=1, RAMP_UP=2, RUN=3, RAMP_DN=4, MUTED=5.
- IDLE:
  - gain=0 and settle counter=0.
  - Goes to SETTLE on the first cycle with enable=1.
- SETTLE:
  - Counts frame176_stb pulses.
  - When the count reaches SETTLE_FRAMES: goes to MUTED if mute_req=1, else to RAMP_UP.
  - Mute wins if both happen in the same cycle.
- RAMP_UP:
  - On each frame88_stb, gain = min(gain+RAMP_STEP, 32768).
  - Goes to RUN in the cycle gain reaches 32768.
  - mute_req=1 goes to RAMP_DN immediately, keeping the current gain.
- RUN:
  - gain holds at 32768.
  - mute_req=1 goes to RAMP_DN.
- RAMP_DN:
  - On each frame88_stb, gain = max(gain-RAMP_STEP, 0).
  - Goes to MUTED when gain reaches 0.
  - mute_req deasserted goes to RAMP_UP from the current gain.
- MUTED:
  - gain=0.
  - mute_req=0 goes to RAMP_UP.
- enable=0 in any state: next cycle goes to IDLE, gain=0, ph=0, settle counter=0, pcm_*_out=0. Further strobes are suppressed.
- Output path, evaluated at each frame88_stb:
  - pcm_x_out <= (pcm_x_in * gain) >>> 15, using a 48-bit signed product and an arithmetic shift (floor toward minus infinity).
  - The result always fits in 32 bits, so no saturation is needed.
  - out_valid pulses the following cycle, aligned with the new data: latency 1 mclk from the strobe.
- A gain step and a sample in the same frame88_stb: the sample uses the pre-update gain.
- Reset asserted mid-operation: immediate return to reset values; no partial ramp is retained.

Optional Feature:
- Macro: ADC_SEQ_CLIP_DET_EN.
- When defined:
  - Adds input clip_clr (1 bit) and output clip_flag (1 bit), reset 0.
  - clip_flag sets, sticky, when either pcm_*_in magnitude is >= 2^31-2^24 on 4 consecutive frame88_stb samples.
  - clip_flag clears on clip_clr=1; set wins over clear in the same cycle.
- When undefined: neither port exists and there is no clip logic.

Test Plan:
- Phase timing: reset, then enable=1 -> dsd_stb every 8 mclk, frame176_stb every 256, frame88_stb every 512; ch_sel toggles every 128 mclk.
- Start-up (SETTLE_FRAMES=4, RAMP_STEP=8192), pcm_left_in=1000 -> expected sequence:
  - State SETTLE, then RAMP_UP after 4 frame176 strobes.
  - gain steps 8192, 16384, 24576, 32768, then RUN.
  - pcm_left_out steps 0, 250, 500, 750, 1000.
- Mute mid-ramp: mute_req=1 at gain=16384 -> RAMP_DN, gain 8192 then 0 -> MUTED, and pcm_*_out=0. Release -> RAMP_UP.
- Simultaneous mute_req and settle completion -> state MUTED, gain stays 0.
- Negative rounding: pcm_right_in=-1, gain=16384 -> pcm_right_out=-1.
- Negative full scale: pcm_right_in=-2^31 at unity -> pcm_right_out=-2^31.
- Drop enable in RUN -> next cycle state IDLE, gain 0, no strobes.
- Reset mid-RAMP_UP -> all outputs 0.
